// File: rtl/vx_smem_responder.sv
// Shared-memory responder for the per-lane dcache protocol: banked scratchpad with per-bank
// arbitration, same-word load broadcast and a single registered merged load response.
module vx_smem_responder #(
  parameter int unsigned NUM_REQS   = 4,
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned WORD_SIZE  = 4,
  parameter int unsigned SIZE       = 16384,
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned TAG_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQS-1:0]               req_valid,
  input  logic [NUM_REQS-1:0]               req_rw,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQS*WORD_SIZE-1:0]     req_byteen,
  input  logic [NUM_REQS*WORD_SIZE*8-1:0]   req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]     req_tag,
  output logic [NUM_REQS-1:0]               req_ready,
  output logic                              rsp_valid,
  output logic [NUM_REQS-1:0]               rsp_tmask,
  output logic [NUM_REQS*WORD_SIZE*8-1:0]   rsp_data,
  output logic [TAG_WIDTH-1:0]              rsp_tag,
  input  logic                              rsp_ready
);

  localparam int unsigned WORD_W    = WORD_SIZE * 8;
  localparam int unsigned BANK_BITS = $clog2(NUM_BANKS);
  localparam int unsigned BANK_W    = (BANK_BITS == 0) ? 1 : BANK_BITS;
  localparam int unsigned ROWS      = SIZE / (NUM_BANKS * WORD_SIZE);
  localparam int unsigned ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;

  function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_WIDTH-1:0] a);
    if (NUM_BANKS == 1) return '0;
    return a[BANK_W-1:0];
  endfunction

  // Upper address bits beyond the scratchpad size wrap via the modulo.
  function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] w;
    w = (a >> BANK_BITS) % ADDR_WIDTH'(ROWS);
    return w[ROW_W-1:0];
  endfunction

  logic [WORD_W-1:0]     mem [NUM_BANKS][ROWS];

  logic [ADDR_WIDTH-1:0] lane_addr   [NUM_REQS];
  logic [BANK_W-1:0]     lane_bank   [NUM_REQS];
  logic [ROW_W-1:0]      lane_row    [NUM_REQS];
  logic [TAG_WIDTH-1:0]  lane_tag    [NUM_REQS];
  logic [WORD_SIZE-1:0]  lane_byteen [NUM_REQS];
  logic [WORD_W-1:0]     lane_data   [NUM_REQS];

  logic                  rsp_stall;
  logic [TAG_WIDTH-1:0]  leader_tag;
  logic [NUM_REQS-1:0]   granted;
  logic [NUM_REQS-1:0]   load_fire;
  logic [NUM_REQS-1:0]   store_fire;

  logic                         rsp_valid_d, rsp_valid_q;
  logic [NUM_REQS-1:0]          rsp_tmask_d, rsp_tmask_q;
  logic [NUM_REQS*WORD_W-1:0]   rsp_data_d,  rsp_data_q;
  logic [TAG_WIDTH-1:0]         rsp_tag_d,   rsp_tag_q;

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      lane_addr[i]   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      lane_bank[i]   = bank_of(req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
      lane_row[i]    = row_of(req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
      lane_tag[i]    = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
      lane_byteen[i] = req_byteen[i*WORD_SIZE +: WORD_SIZE];
      lane_data[i]   = req_data[i*WORD_W +: WORD_W];
    end
  end

  assign rsp_stall = rsp_valid_q & ~rsp_ready;

  // Leader-tag selection and per-bank arbitration; a load winner also grants same-word loads.
  always_comb begin : grant_logic
    logic                  leader_found;
    logic [NUM_REQS-1:0]   cand;
    logic                  win_found;
    logic                  win_rw;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [NUM_REQS-1:0]   win_oh;
    leader_found = 1'b0;
    leader_tag   = '0;
    cand         = '0;
    granted      = '0;
    win_found    = 1'b0;
    win_rw       = 1'b0;
    win_addr     = '0;
    win_oh       = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (!leader_found && req_valid[i] && !req_rw[i] && !rsp_stall) begin
        leader_found = 1'b1;
        leader_tag   = lane_tag[i];
      end
    end
    for (int i = 0; i < NUM_REQS; i++) begin
      cand[i] = req_valid[i] && (req_rw[i] || (!rsp_stall && (lane_tag[i] == leader_tag)));
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      win_found = 1'b0;
      win_rw    = 1'b0;
      win_addr  = '0;
      win_oh    = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
        if (!win_found && cand[i] && (lane_bank[i] == BANK_W'(b))) begin
          win_found = 1'b1;
          win_rw    = req_rw[i];
          win_addr  = lane_addr[i];
          win_oh[i] = 1'b1;
        end
      end
      if (win_found && win_rw) begin
        granted = granted | win_oh;
      end else if (win_found) begin
        for (int i = 0; i < NUM_REQS; i++) begin
          if (cand[i] && !req_rw[i] && (lane_bank[i] == BANK_W'(b)) && (lane_addr[i] == win_addr))
            granted[i] = 1'b1;
        end
      end
    end
  end

  assign req_ready  = reset ? '0 : granted;
  assign load_fire  = req_ready & ~req_rw;
  assign store_fire = req_ready & req_rw;

  // Response register holds while stalled; otherwise reflects this cycle's load fires.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_tmask_d = rsp_tmask_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    if (!rsp_stall) begin
      rsp_valid_d = |load_fire;
      if (|load_fire) begin
        rsp_tmask_d = load_fire;
        rsp_tag_d   = leader_tag;
        for (int i = 0; i < NUM_REQS; i++) begin
          rsp_data_d[i*WORD_W +: WORD_W] = load_fire[i] ? mem[lane_bank[i]][lane_row[i]] : '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_tmask_q <= '0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_tmask_q <= rsp_tmask_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

  // Byte-masked store write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQS; i++) begin
      if (store_fire[i]) begin
        for (int j = 0; j < WORD_SIZE; j++) begin
          if (lane_byteen[i][j])
            mem[lane_bank[i]][lane_row[i]][j*8 +: 8] <= lane_data[i][j*8 +: 8];
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_tmask = rsp_tmask_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_addr_chk
    a_addr_known : assert property (@(posedge clk) disable iff (reset)
      !(req_valid[g] && $isunknown(req_addr[g*ADDR_WIDTH +: ADDR_WIDTH])));
  end

  a_tmask_nonzero : assert property (@(posedge clk) disable iff (reset)
    rsp_valid_q |-> (rsp_tmask_q != '0));

endmodule
